stack_ctrl: RTL
===============

// Module: stack_ctrl
// PURPOSE
// - LIFO stack controller sitting directly upstream of the dual-port stack memory; it drives that memory's in/ind1/ind2/beta
//   pins and consumes its out1/out2 pins.
// - Accepts PUSH/POP/TOP commands over a valid/ready handshake and owns the stack pointer.
// - Sequences the memory's write strobe and read latency; returns one result per command with full/empty/error status.
// PARAMETERS
// - N        1024          stack depth (entries); must match the memory's N
// - M        32            data width; must match the memory's M
// - IND_SIZE $clog2(N)     address width
// - WAIT_CYC 1             clock cycles from address stable to out1/out2 sampled; >=1, covers memory RITARDO
// PORTS
// - clock     in  1         single clock, rising edge
// - reset_n   in  1         asynchronous, active-low reset
// - op_valid  in  1         command present
// - op_ready  out 1         controller can accept a command
// - op_code   in  2         00=PUSH 01=POP 10=TOP 11=reserved (treated as TOP)
// - op_data   in  M         PUSH operand
// - res_valid out 1         result present; held until res_ready
// - res_ready in  1         consumer takes result
// - res_data  out M         POP/TOP value; PUSH echoes op_data; 0 on error
// - res_err   out 1         overflow (PUSH when full) or underflow (POP/TOP when empty)
// - count     out IND_SIZE+1 entries on stack (= stack pointer)
// - full      out 1         count==N
// - empty     out 1         count==0
// - res_second out M       (STACK_SECOND_EN only) entry below top
// - mem_in    out M         to memory 'in'
// - mem_ind1  out IND_SIZE  to memory 'ind1' (read/write port)
// - mem_ind2  out IND_SIZE  to memory 'ind2' (read port)
// - mem_beta  out 1         to memory 'beta'; write enable
// - mem_out1  in  M         from memory 'out1'
// - mem_out2  in  M         from memory 'out2'
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, count=0, empty=1, full=0, op_ready=1, res_valid=0, res_err=0, res_data=0,
//   res_second=0, mem_beta=0, mem_ind1=0, mem_ind2=0, mem_in=0.
// - Reset mid-operation aborts the command; no write is issued after reset_n falls. Memory contents are not cleared.
// - States: IDLE, WRITE, READ, RESP.
// - IDLE: op_ready=1. Handshake op_valid&op_ready latches op_code/op_data.
//   - PUSH && !full -> WRITE
//   - POP/TOP && !empty -> READ
//   - error case -> RESP with res_err=1, res_data=0, count unchanged, no memory access
// - WRITE (1 cycle): mem_ind1=count, mem_in=data, mem_beta=1 (memory writes on this cycle's closing edge).
//   - On the same edge: count+=1; -> RESP with res_data=data, res_err=0.
// - READ (WAIT_CYC cycles): mem_ind1=count-1, mem_ind2=count-2 (mod N), mem_beta=0.
//   - On the last READ edge: res_data<=mem_out1; POP also does count-=1 on that edge; TOP leaves count unchanged. -> RESP
// - RESP: res_valid=1, op_ready=0; outputs stable until res_valid&res_ready -> IDLE (op_ready=1 next cycle).
// - Latency, accept edge = E:
//   - PUSH: res_valid high after E+2
//   - POP/TOP: res_valid high after E+1+WAIT_CYC
//   - errors: res_valid high after E+1
// - Throughput: one command in flight. op_valid during WRITE/READ/RESP is ignored (op_ready=0).
// - mem_beta is high only in WRITE; never two consecutive cycles.
// - full/empty/count are registered and update on the same edge as the pointer change.
// - Wrap: count spans 0..N; mem_ind1 = low IND_SIZE bits.
// CONFIGURATION
// - STACK_SECOND_EN defined:
//   - res_second port exists. On POP/TOP it returns mem_out2 (entry count-2) when count>=2 at accept, else 0.
//   - res_second is sampled on the same edge as res_data. PUSH and errors give res_second=0.
// - STACK_SECOND_EN undefined: no res_second port; mem_ind2 tied to 0.
// TESTING
// - Reset with count=0, then POP -> res_valid after 1 cycle, res_err=1, res_data=0, count=0, mem_beta never high.
// - PUSH 0xA, 0xB, 0xC; then TOP -> res_data=0xC, count=3. Then POP x3 -> 0xC, 0xB, 0xA; empty=1 after the third.
// - N=4: PUSH 1..4 -> full=1; 5th PUSH -> res_err=1, no mem_beta pulse, TOP still returns 4.
// - Hold res_ready=0 for 5 cycles after POP -> res_valid/res_data held and op_ready=0. Raise res_ready -> op_ready=1 next cycle.
// - Assert reset_n=0 during READ -> immediate reset values. After release, count=0 and a PUSH proceeds normally.
// - With STACK_SECOND_EN: PUSH 7, PUSH 9, POP -> res_data=9, res_second=7. POP -> res_data=7, res_second=0.

Source files
------------

// File: rtl/stack_ctrl.sv
// LIFO stack controller driving a dual-port stack memory; owns the stack pointer.
// Latency from accept edge: error 1 cycle, PUSH 2 cycles, POP/TOP 1+WAIT_CYC cycles.
// One command in flight; op_ready low until the result is taken (res_valid & res_ready).
// Optional feature macro: STACK_SECOND_EN adds res_second (entry below top) and drives mem_ind2.
module stack_ctrl #(
  parameter int N        = 1024,
  parameter int M        = 32,
  parameter int IND_SIZE = $clog2(N),
  parameter int WAIT_CYC = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_code,
  input  logic [M-1:0]        op_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [M-1:0]        res_data,
  output logic                res_err,
  output logic [IND_SIZE:0]   count,
  output logic                full,
  output logic                empty,
`ifdef STACK_SECOND_EN
  output logic [M-1:0]        res_second,
`endif
  output logic [M-1:0]        mem_in,
  output logic [IND_SIZE-1:0] mem_ind1,
  output logic [IND_SIZE-1:0] mem_ind2,
  output logic                mem_beta,
  input  logic [M-1:0]        mem_out1,
  input  logic [M-1:0]        mem_out2
);

  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [IND_SIZE:0] FULL_CNT = (IND_SIZE+1)'(N);
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t              state_q;
  logic [IND_SIZE:0]   count_q, count_d;
  logic                full_q, empty_q;
  logic                op_ready_q, res_valid_q, res_err_q, mem_beta_q;
  logic [M-1:0]        res_data_q, mem_in_q;
  logic [IND_SIZE-1:0] mem_ind1_q;
  logic                pop_q;
  logic [WW-1:0]       wait_q;
  logic                read_last;
  logic [IND_SIZE-1:0] ind_top;

  // Last READ cycle: memory outputs have had WAIT_CYC cycles to settle.
  assign read_last = (wait_q == WW'(WAIT_CYC - 1));
  // Address of the current top entry; wraps modulo the memory depth.
  assign ind_top   = count_q[IND_SIZE-1:0] - IND_SIZE'(1);

  // Next stack pointer: grows on the WRITE edge, shrinks on the final POP read edge.
  always_comb begin
    count_d = count_q;
    if (state_q == WRITE)
      count_d = count_q + (IND_SIZE+1)'(1);
    else if (state_q == READ && read_last && pop_q)
      count_d = count_q - (IND_SIZE+1)'(1);
  end

`ifdef STACK_SECOND_EN
  logic [IND_SIZE-1:0] mem_ind2_q;
  logic [M-1:0]        res_second_q;
  logic                second_ok_q;
  assign mem_ind2   = mem_ind2_q;
  assign res_second = res_second_q;

  // Second-from-top capture; the entry only exists when at least two were stacked at accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_ind2_q   <= '0;
      res_second_q <= '0;
      second_ok_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (op_valid && op_code != OP_PUSH && !empty_q) begin
          mem_ind2_q  <= ind_top - IND_SIZE'(1);
          second_ok_q <= (count_q >= (IND_SIZE+1)'(2));
        end else if (op_valid) begin
          res_second_q <= '0;
        end
        WRITE: res_second_q <= '0;
        READ:  if (read_last) res_second_q <= second_ok_q ? mem_out2 : '0;
        default: ;
      endcase
    end
  end
`else
  logic unused_mem_out2;
  assign unused_mem_out2 = ^mem_out2;
  assign mem_ind2        = '0;
`endif

  // Main sequencer: accepts a command, drives the memory pins, holds the result until taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      mem_in_q    <= '0;
      mem_ind1_q  <= '0;
      mem_beta_q  <= 1'b0;
      pop_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      mem_beta_q <= 1'b0;
      count_q    <= count_d;
      full_q     <= (count_d == FULL_CNT);
      empty_q    <= (count_d == '0);
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            op_ready_q <= 1'b0;
            if ((op_code == OP_PUSH) ? full_q : empty_q) begin
              state_q     <= RESP;
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
            end else if (op_code == OP_PUSH) begin
              state_q    <= WRITE;
              mem_ind1_q <= count_q[IND_SIZE-1:0];
              mem_in_q   <= op_data;
              mem_beta_q <= 1'b1;
            end else begin
              state_q    <= READ;
              pop_q      <= (op_code == OP_POP);
              mem_ind1_q <= ind_top;
              wait_q     <= '0;
            end
          end
        end
        WRITE: begin
          state_q     <= RESP;
          res_valid_q <= 1'b1;
          res_err_q   <= 1'b0;
          res_data_q  <= mem_in_q;
        end
        READ: begin
          if (read_last) begin
            state_q     <= RESP;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b0;
            res_data_q  <= mem_out1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign mem_in    = mem_in_q;
  assign mem_ind1  = mem_ind1_q;
  assign mem_beta  = mem_beta_q;

endmodule
